// File: rtl/mvm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvm_pkg : state type, slot addressing and range-fit helpers for mvm_tiled
// Revision 1.0
// ---------------------------------------------------------------------------
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Working width of fit_result; lanes sign-extend their sums to this width.
  localparam int FIT_W = 64;

  function automatic int slot_lsb(input int i, input int n, input int w);
    return (n - 1 - i) * w;
  endfunction

  // Returns {ovf, value}; value[width-1:0] is the wrapped or clamped result.
  function automatic logic [FIT_W:0] fit_result(input logic signed [FIT_W-1:0] s,
                                                input logic signed_mode,
                                                input logic saturate,
                                                input int width);
    logic signed [FIT_W-1:0] hi;
    logic signed [FIT_W-1:0] lo;
    logic                    ovf;
    logic        [FIT_W-1:0] val;
    if (signed_mode) begin
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
    end else begin
      hi = (64'sd1 <<< width) - 64'sd1;
      lo = 64'sd0;
    end
    ovf = (s > hi) || (s < lo);
    val = s;
    if (saturate && (s > hi)) val = hi;
    else if (saturate && (s < lo)) val = lo;
    return {ovf, val};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvm_lane : one multiply-accumulate lane plus bias, ReLU and range fit
// Revision 1.0
// ---------------------------------------------------------------------------
module mvm_lane
  import mvm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             acc_clr,
  input  logic             acc_en,
  input  logic             signed_mode,
  input  logic             saturate,
  input  logic             relu,
  input  logic [WIDTH-1:0] m_elem,
  input  logic [WIDTH-1:0] v_elem,
  input  logic [WIDTH-1:0] bias,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int EXT = ACC_WIDTH - WIDTH;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] m_ext;
  logic signed [ACC_WIDTH-1:0] v_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] sum_raw;
  logic signed [ACC_WIDTH-1:0] sum;
  logic        [FIT_W:0]       fit;
  logic                        unused_fit_bits;

  assign m_ext = {{EXT{signed_mode & m_elem[WIDTH-1]}}, m_elem};
  assign v_ext = {{EXT{signed_mode & v_elem[WIDTH-1]}}, v_elem};
  assign b_ext = {{EXT{signed_mode & bias[WIDTH-1]}}, bias};
  assign prod  = m_ext * v_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    acc <= '0;
    else if (acc_clr) acc <= '0;
    else if (acc_en)  acc <= acc + prod;
  end

  // ReLU only has meaning for two's-complement sums.
  assign sum_raw = acc + b_ext;
  assign sum     = (relu && signed_mode && sum_raw[ACC_WIDTH-1]) ? '0 : sum_raw;

  assign fit = fit_result({{(FIT_W-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum},
                          signed_mode, saturate, WIDTH);

  assign ovf             = fit[FIT_W];
  assign result          = fit[WIDTH-1:0];
  assign unused_fit_bits = ^fit[FIT_W-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/mvm_tiled.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvm_tiled : result = f(M*v + b), LANES rows per pass, valid/ready on both ends
// Revision 1.0
// ---------------------------------------------------------------------------
module mvm_tiled
  import mvm_pkg::*;
#(
  parameter int MATRIX_ROWS = 4,
  parameter int SHARED_DIM  = 4,
  parameter int WIDTH       = 8,
  parameter int LANES       = 2
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    clear,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
  input  logic [SHARED_DIM*WIDTH-1:0]             vector,
  input  logic [MATRIX_ROWS*WIDTH-1:0]            bias,
  input  logic                                    signed_mode,
  input  logic                                    saturate,
  input  logic                                    relu,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [MATRIX_ROWS*WIDTH-1:0]            result_vector,
  output logic                                    overflow
);

  localparam int PASSES    = MATRIX_ROWS / LANES;
  localparam int ACC_WIDTH = 2*WIDTH + $clog2(SHARED_DIM) + 2;
  localparam int PASS_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int COL_W     = (SHARED_DIM > 1) ? $clog2(SHARED_DIM) : 1;

  state_t                                  state;
  logic [PASS_W-1:0]                       pass_cnt;
  logic [COL_W-1:0]                        col_cnt;
  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] m_reg;
  logic [SHARED_DIM*WIDTH-1:0]             v_reg;
  logic [MATRIX_ROWS*WIDTH-1:0]            b_reg;
  logic                                    mode_signed;
  logic                                    mode_sat;
  logic                                    mode_relu;
  logic [WIDTH-1:0]                        res_q [PASSES][LANES];

  logic [WIDTH-1:0] m_arr [PASSES][LANES][SHARED_DIM];
  logic [WIDTH-1:0] v_arr [SHARED_DIM];
  logic [WIDTH-1:0] b_arr [PASSES][LANES];
  logic [WIDTH-1:0] lane_res [LANES];
  logic [LANES-1:0] lane_ovf;
  logic             acc_clr;
  logic             acc_en;

  // Unpack the captured operands into (pass, lane, column) order.
  for (genvar c = 0; c < SHARED_DIM; c++) begin : g_vec
    assign v_arr[c] = v_reg[slot_lsb(c, SHARED_DIM, WIDTH) +: WIDTH];
  end

  for (genvar p = 0; p < PASSES; p++) begin : g_pass
    for (genvar l = 0; l < LANES; l++) begin : g_row
      localparam int ROW = p*LANES + l;
      assign b_arr[p][l] = b_reg[slot_lsb(ROW, MATRIX_ROWS, WIDTH) +: WIDTH];
      assign result_vector[slot_lsb(ROW, MATRIX_ROWS, WIDTH) +: WIDTH] = res_q[p][l];
      for (genvar c = 0; c < SHARED_DIM; c++) begin : g_col
        assign m_arr[p][l][c] =
          m_reg[slot_lsb(ROW*SHARED_DIM + c, MATRIX_ROWS*SHARED_DIM, WIDTH) +: WIDTH];
      end
    end
  end

  // FINAL reads the sums and clears them on the same edge, ready for the next pass.
  assign acc_clr = clear || (state != MAC);
  assign acc_en  = (state == MAC);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mvm_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .acc_clr     (acc_clr),
      .acc_en      (acc_en),
      .signed_mode (mode_signed),
      .saturate    (mode_sat),
      .relu        (mode_relu),
      .m_elem      (m_arr[pass_cnt][l][col_cnt]),
      .v_elem      (v_arr[col_cnt]),
      .bias        (b_arr[pass_cnt][l]),
      .result      (lane_res[l]),
      .ovf         (lane_ovf[l])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      pass_cnt    <= '0;
      col_cnt     <= '0;
      m_reg       <= '0;
      v_reg       <= '0;
      b_reg       <= '0;
      mode_signed <= 1'b0;
      mode_sat    <= 1'b0;
      mode_relu   <= 1'b0;
      for (int p = 0; p < PASSES; p++)
        for (int l = 0; l < LANES; l++)
          res_q[p][l] <= '0;
    end else if (clear) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      pass_cnt  <= '0;
      col_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state       <= MAC;
            in_ready    <= 1'b0;
            overflow    <= 1'b0;
            pass_cnt    <= '0;
            col_cnt     <= '0;
            m_reg       <= matrix;
            v_reg       <= vector;
            b_reg       <= bias;
            mode_signed <= signed_mode;
            mode_sat    <= saturate;
            mode_relu   <= relu;
          end
        end
        MAC: begin
          if (col_cnt == COL_W'(SHARED_DIM - 1)) begin
            col_cnt <= '0;
            state   <= FINAL;
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end
        FINAL: begin
          for (int l = 0; l < LANES; l++)
            res_q[pass_cnt][l] <= lane_res[l];
          overflow <= overflow | (|lane_ovf);
          if (pass_cnt == PASS_W'(PASSES - 1)) begin
            pass_cnt  <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            pass_cnt <= pass_cnt + PASS_W'(1);
            state    <= MAC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvm_tiled.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mvm_tiled : directed bench over three mvm_tiled configurations
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mvm_tiled;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic signed_mode = 1'b0;
  logic saturate = 1'b0;
  logic relu = 1'b0;
  logic out_ready = 1'b1;

  always #5 clk = ~clk;

  // A: 3x3, one lane
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_overflow;
  logic [71:0] a_matrix = '0;
  logic [23:0] a_vector = '0, a_bias = '0, a_result;
  // B: 2x4, two lanes
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_overflow;
  logic [63:0] b_matrix = '0;
  logic [31:0] b_vector = '0;
  logic [15:0] b_bias = '0, b_result;
  // C: defaults 4x4, two lanes
  logic         c_in_valid = 1'b0, c_in_ready, c_out_valid, c_overflow;
  logic [127:0] c_matrix = '0;
  logic [31:0]  c_vector = '0, c_bias = '0, c_result;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [71:0] M_COMPAT = 72'h010203040506070809;
  localparam logic [71:0] M_BIG    = 72'h131415161718191A1B;
  localparam logic [127:0] M_IDENT = 128'h01000000_00010000_00000100_00000001;

  mvm_tiled #(.MATRIX_ROWS(3), .SHARED_DIM(3), .WIDTH(8), .LANES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .matrix(a_matrix), .vector(a_vector), .bias(a_bias), .signed_mode(signed_mode),
    .saturate(saturate), .relu(relu), .out_valid(a_out_valid), .out_ready(out_ready),
    .result_vector(a_result), .overflow(a_overflow));

  mvm_tiled #(.MATRIX_ROWS(2), .SHARED_DIM(4), .WIDTH(8), .LANES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .matrix(b_matrix), .vector(b_vector), .bias(b_bias), .signed_mode(signed_mode),
    .saturate(saturate), .relu(relu), .out_valid(b_out_valid), .out_ready(out_ready),
    .result_vector(b_result), .overflow(b_overflow));

  mvm_tiled dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .matrix(c_matrix), .vector(c_vector), .bias(c_bias), .signed_mode(signed_mode),
    .saturate(saturate), .relu(relu), .out_valid(c_out_valid), .out_ready(out_ready),
    .result_vector(c_result), .overflow(c_overflow));

  function automatic logic sel_valid(input int w);
    case (w)
      0:       return a_out_valid;
      1:       return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic logic [31:0] sel_result(input int w);
    case (w)
      0:       return {8'h00, a_result};
      1:       return {16'h0000, b_result};
      default: return c_result;
    endcase
  endfunction

  function automatic logic sel_ovf(input int w);
    case (w)
      0:       return a_overflow;
      1:       return b_overflow;
      default: return c_overflow;
    endcase
  endfunction

  // Stimulus only: one accepted operation; lat = -1 when out_valid never rises.
  task automatic run_op(input int which, input logic [127:0] m, input logic [31:0] v,
                        input logic [31:0] b, input logic sm, input logic sat, input logic rl,
                        output int lat, output logic [31:0] res, output logic ovf);
    signed_mode = sm; saturate = sat; relu = rl;
    case (which)
      0: begin a_matrix = m[71:0]; a_vector = v[23:0]; a_bias = b[23:0]; a_in_valid = 1'b1; end
      1: begin b_matrix = m[63:0]; b_vector = v;       b_bias = b[15:0]; b_in_valid = 1'b1; end
      default: begin c_matrix = m; c_vector = v; c_bias = b; c_in_valid = 1'b1; end
    endcase
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (sel_valid(which)) begin lat = i; break; end
    end
    res = sel_result(which);
    ovf = sel_ovf(which);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({a_out_valid, a_overflow, a_result} !== 26'h0) begin
      miscompares++; $display("FAIL reset_a: got valid/ovf/res %b/%b/%h, want 0/0/000000", a_out_valid, a_overflow, a_result);
    end
    vectors++;
    if ({b_out_valid, b_overflow, b_result} !== 18'h0) begin
      miscompares++; $display("FAIL reset_b: got valid/ovf/res %b/%b/%h, want 0/0/0000", b_out_valid, b_overflow, b_result);
    end
    vectors++;
    if ({c_out_valid, c_overflow, c_result} !== 34'h0) begin
      miscompares++; $display("FAIL reset_c: got valid/ovf/res %b/%b/%h, want 0/0/00000000", c_out_valid, c_overflow, c_result);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      miscompares++; $display("FAIL reset_in_ready: got %b, want 111", {a_in_ready, b_in_ready, c_in_ready});
    end
  endtask

  task automatic test_unsigned;
    int lat; logic [31:0] res; logic ovf;
    run_op(0, {56'h0, M_COMPAT}, 32'h010203, 32'h0, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (res[23:0] !== 24'h0E2032) begin miscompares++; $display("FAIL compat_result: got %h, want 0e2032", res[23:0]); end
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL compat_ovf: got %b, want 0", ovf); end
    vectors++;
    if (lat !== 12) begin miscompares++; $display("FAIL compat_latency: got %0d, want 12", lat); end
    run_op(0, {56'h0, M_BIG}, 32'h070809, 32'h0, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if ({ovf, res[23:0]} !== {1'b1, 24'hE22A72}) begin
      miscompares++; $display("FAIL big_wrap: got ovf/res %b/%h, want 1/e22a72", ovf, res[23:0]);
    end
    run_op(0, {56'h0, M_BIG}, 32'h070809, 32'h0, 1'b0, 1'b1, 1'b0, lat, res, ovf);
    vectors++;
    if ({ovf, res[23:0]} !== {1'b1, 24'hFFFFFF}) begin
      miscompares++; $display("FAIL big_saturate: got ovf/res %b/%h, want 1/ffffff", ovf, res[23:0]);
    end
    run_op(0, {56'h0, M_COMPAT}, 32'h010203, 32'h010101, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if ({ovf, res[23:0]} !== {1'b0, 24'h0F2133}) begin
      miscompares++; $display("FAIL bias: got ovf/res %b/%h, want 0/0f2133", ovf, res[23:0]);
    end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] res; logic ovf;
    run_op(1, {64'h0, 64'h01FE03FCFC03FE01}, 32'h01FE03FC, 32'h0, 1'b1, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if ({ovf, res[15:0]} !== {1'b0, 16'h1EEC}) begin
      miscompares++; $display("FAIL signed_wrap: got ovf/res %b/%h, want 0/1eec", ovf, res[15:0]);
    end
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL signed_latency: got %0d, want 5", lat); end
    run_op(1, {64'h0, 64'h01FE03FCFC03FE01}, 32'h01FE03FC, 32'h0, 1'b1, 1'b0, 1'b1, lat, res, ovf);
    vectors++;
    if ({ovf, res[15:0]} !== {1'b0, 16'h1E00}) begin
      miscompares++; $display("FAIL signed_relu: got ovf/res %b/%h, want 0/1e00", ovf, res[15:0]);
    end
  endtask

  task automatic test_identity;
    int lat; logic [31:0] res; logic ovf;
    run_op(2, M_IDENT, 32'h05060708, 32'h0, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if ({ovf, res} !== {1'b0, 32'h05060708}) begin
      miscompares++; $display("FAIL identity: got ovf/res %b/%h, want 0/05060708", ovf, res);
    end
    vectors++;
    if (lat !== 10) begin miscompares++; $display("FAIL identity_latency: got %0d, want 10", lat); end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b0;
    signed_mode = 1'b0; saturate = 1'b0; relu = 1'b0;
    a_matrix = M_COMPAT; a_vector = 24'h010203; a_bias = 24'h0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin lat = i; break; end
    end
    vectors++;
    if (lat !== 12) begin miscompares++; $display("FAIL bp_first_latency: got %0d, want 12", lat); end
    // New operands offered while the result is held.
    a_matrix = M_BIG; a_vector = 24'h070809; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({a_out_valid, a_in_ready, a_overflow, a_result} !== {3'b100, 24'h0E2032}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid/rdy/ovf/res %b/%b/%b/%h, want 1/0/0/0e2032",
                 i, a_out_valid, a_in_ready, a_overflow, a_result);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_release: got valid/rdy %b/%b, want 0/1", a_out_valid, a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    vectors++;
    if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_second_accept: got in_ready %b, want 0", a_in_ready); end
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin lat = i; break; end
    end
    vectors++;
    if ({lat, a_overflow, a_result} !== {32'd12, 1'b1, 24'hE22A72}) begin
      miscompares++; $display("FAIL bp_second: got lat/ovf/res %0d/%b/%h, want 12/1/e22a72", lat, a_overflow, a_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    int lat; logic [31:0] res; logic ovf; logic seen;
    signed_mode = 1'b0; saturate = 1'b0; relu = 1'b0;
    a_matrix = M_COMPAT; a_vector = 24'h010203; a_bias = 24'h0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    vectors++;
    if ({a_out_valid, a_in_ready, a_result} !== {2'b01, 24'hE22A72}) begin
      miscompares++; $display("FAIL clear_state: got valid/rdy/res %b/%b/%h, want 0/1/e22a72", a_out_valid, a_in_ready, a_result);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL clear_no_valid: got out_valid seen %b, want 0", seen); end
    run_op(0, {56'h0, M_COMPAT}, 32'h010203, 32'h010101, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if ({lat, ovf, res[23:0]} !== {32'd12, 1'b0, 24'h0F2133}) begin
      miscompares++; $display("FAIL clear_follow: got lat/ovf/res %0d/%b/%h, want 12/0/0f2133", lat, ovf, res[23:0]);
    end
  endtask

  task automatic test_abort_reset;
    int lat; logic [31:0] res; logic ovf; logic seen;
    signed_mode = 1'b0; saturate = 1'b0; relu = 1'b0;
    c_matrix = M_IDENT; c_vector = 32'h0A0B0C0D; c_bias = 32'h0; c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    vectors++;
    if (c_result[31:16] !== 16'h0A0B) begin
      miscompares++; $display("FAIL abort_pass0: got rows0-1 %h, want 0a0b", c_result[31:16]);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({c_out_valid, c_overflow, c_result} !== 34'h0) begin
      miscompares++; $display("FAIL abort_reset: got valid/ovf/res %b/%b/%h, want 0/0/00000000", c_out_valid, c_overflow, c_result);
    end
    #2 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (c_out_valid) seen = 1'b1;
    end
    vectors++;
    if ({seen, c_in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL abort_idle: got seen/rdy %b/%b, want 0/1", seen, c_in_ready);
    end
    run_op(2, M_IDENT, 32'h11223344, 32'h01010101, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if ({lat, ovf, res} !== {32'd10, 1'b0, 32'h12233445}) begin
      miscompares++; $display("FAIL abort_follow: got lat/ovf/res %0d/%b/%h, want 10/0/12233445", lat, ovf, res);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_identity();
    test_back_to_back();
    test_clear();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mvm_tiled.md
# mvm_tiled

Parametrised matrix-vector multiply engine, the next generation of the `mvm` block in the neural-network accelerator datapath. It computes `result = f(M·v + b)` over a packed `MATRIX_ROWS × SHARED_DIM` matrix using `LANES` parallel multiply-accumulate lanes. It adds signed/unsigned arithmetic, per-row bias, optional ReLU, and wrap/saturate output modes. It uses valid/ready handshakes on input and output so it can sit between the weight/activation buffers and the next layer stage with backpressure.

## Interface

Parameters:

- `MATRIX_ROWS`, default 4: output rows; must be a multiple of `LANES`.
- `SHARED_DIM`, default 4: matrix columns and vector length; must be at least 1.
- `WIDTH`, default 8: element, bias and result width.
- `LANES`, default 2: rows computed in parallel; must be at least 1.
- Derived localparams:
  - `PASSES = MATRIX_ROWS/LANES`
  - `ACC_WIDTH = 2*WIDTH + $clog2(SHARED_DIM) + 2`

Ports:

- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort; returns to IDLE and discards the current operation.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `matrix`  in  `MATRIX_ROWS*SHARED_DIM*WIDTH`  packed matrix; element (r,c) at slot `r*SHARED_DIM+c`.
- `vector`  in  `SHARED_DIM*WIDTH`  packed vector; element c at slot c.
- `bias`  in  `MATRIX_ROWS*WIDTH`  packed per-row bias; row r at slot r.
- `signed_mode`  in  1  1 = two's-complement operands and results.
- `saturate`  in  1  1 = clamp the result; 0 = wrap it to `WIDTH` bits.
- `relu`  in  1  1 = clamp negative sums to 0 (meaningful in signed mode only).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result_vector`  out  `MATRIX_ROWS*WIDTH`  packed result; row r at slot r.
- `overflow`  out  1  at least one row was out of range before wrapping or clamping.

Slot packing: slot 0 occupies the most-significant `WIDTH` bits. In general, slot i of an N-slot bus is `[(N-1-i)*WIDTH +: WIDTH]`.

## Operation

- States:
  - IDLE → MAC on accept (`in_valid && in_ready`).
  - MAC → FINAL after `SHARED_DIM` cycles.
  - FINAL → MAC for the next pass, or → DONE after pass `PASSES-1`.
  - DONE → IDLE on `out_valid && out_ready`.
- `in_ready` = 1 only in IDLE.
- On accept, the block registers `matrix`, `vector`, `bias` and all three mode bits. Later input changes have no effect on the running operation.
- MAC, pass p, cycle k:
  - lane l computes `acc[l] += M[p*LANES+l][k] * v[k]`.
  - Operands are sign- or zero-extended to `ACC_WIDTH` per `signed_mode`.
  - Accumulators clear at the start of each pass.
  - No intermediate overflow is possible.
- FINAL, per lane:
  - `s = acc + ext(bias[row])`.
  - If `relu` and `signed_mode` and `s < 0`, then `s = 0`.
  - Range check:
    - signed range is `[-2^(WIDTH-1), 2^(WIDTH-1)-1]`;
    - unsigned range is `[0, 2^WIDTH-1]`.
  - Out of range sets the `overflow` accumulator bit. The result is the nearest bound if `saturate`, otherwise `s[WIDTH-1:0]`.
  - The lane writes its row slot of `result_vector`.
- `overflow` clears on accept and ORs across all rows of the operation.

## Timing

- Reset values (asynchronous on `reset_n` low):
  - state IDLE;
  - `in_ready` = 1 after release;
  - `out_valid` = 0, `result_vector` = 0, `overflow` = 0;
  - accumulators 0.
- Latency: with the accept edge at T, `out_valid` rises at edge `T + PASSES*(SHARED_DIM+1)`.
  - Default parameters: 10 cycles.
  - `LANES=1`, 3×3: 12 cycles.
- DONE holding rules:
  - `result_vector` and `overflow` stay stable while `out_valid && !out_ready`.
  - `in_valid` is ignored.
- `out_valid` falls on the handshake edge. `in_ready` rises on the same edge (IDLE), so the next accept happens one cycle after output completion at the earliest.
- `result_vector` keeps its last value after DONE until the next FINAL writes it. Only `out_valid` qualifies it.
- `clear` has priority over every transition. On `clear`, the next state is IDLE and `out_valid` = 0; `result_vector` and `overflow` are retained.
- `reset_n` asserted mid-operation aborts immediately; no partial result is ever flagged valid.

## Structure

- Package `mvm_pkg` holds:
  - the state enum (IDLE, MAC, FINAL, DONE);
  - the slot-index function `slot_lsb(i, N, W)`;
  - the range-check/clamp function `fit_result(s, signed_mode, saturate)`, returning `{ovf, value}`.
- Sub-module `mvm_lane` is one accumulator plus its FINAL logic. The top level instantiates `LANES` copies via generate. The top holds the FSM, pass/column counters, operand registers and output register.

## Test plan

- Default-compat (`ROWS=3, DIM=3, LANES=1`), unsigned wrap:
  - `matrix=72'h010203040506070809`, `vector=24'h010203`, `bias=0` → `result=24'h0E2032`, `overflow=0`, `out_valid` at accept+12.
- Unsigned overflow (same config):
  - `matrix=72'h131415161718191A1B`, `vector=24'h070809`.
  - Wrap → `24'hE22A72`, `overflow=1`.
  - Saturate → `24'hFFFFFF`, `overflow=1`.
  - Bias `24'h010101` on the default-compat case → `24'h0F2133`.
- Signed (`ROWS=2, DIM=4, LANES=2`):
  - `matrix=64'h01FE03FCFC03FE01`, `vector=32'h01FE03FC`.
  - Wrap → `16'h1EEC`.
  - With relu → `16'h1E00`.
  - Both `overflow=0`; `out_valid` at accept+5.
- Default params, `LANES=2`, 4×4 identity matrix, `vector=32'h05060708` → `32'h05060708`, `out_valid` at accept+10.
- Backpressure:
  - Hold `out_ready=0` for 5 cycles with `in_valid=1` and new operands. Result stays stable, `in_ready=0`, and the operands are not captured.
  - Raise `out_ready`: `in_ready=1` at the next edge, then the second operation completes correctly.
- Abort:
  - Drop `reset_n` in pass 1 → all outputs are at reset values immediately.
  - Pulse `clear` in MAC → IDLE with `out_valid=0` and no valid result for that operation.
  - A following operation returns the correct result.
